// File: rtl/mode_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mode_seq_if
// Purpose  : Bundles the raw user buttons and the mode-select outputs of the
//            light-pen screen mode sequencer.
// Ports    : btn_halt/btn_next/btn_prev - raw asynchronous buttons
//            state       - top state (BOOT=0, IDLE=1, RUN=2, HALT=3)
//            mode        - current run mode
//            boot_phase  - current boot blink phase, 0 outside BOOT
//            mode_strobe - one-cycle pulse on any state/mode change
// Modports : master drives the buttons, slave (the sequencer) drives outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface mode_seq_if #(
  parameter int unsigned MODE_W  = 3,
  parameter int unsigned PHASE_W = 2
);
  logic               btn_halt;
  logic               btn_next;
  logic               btn_prev;
  logic [2:0]         state;
  logic [MODE_W-1:0]  mode;
  logic [PHASE_W-1:0] boot_phase;
  logic               mode_strobe;

  modport master (
    output btn_halt, btn_next, btn_prev,
    input  state, mode, boot_phase, mode_strobe
  );

  modport slave (
    input  btn_halt, btn_next, btn_prev,
    output state, mode, boot_phase, mode_strobe
  );
endinterface
`default_nettype wire

// File: rtl/mode_seq.sv
`default_nettype none
// ============================================================================
// Module   : mode_seq
// Purpose  : Top-level mode sequencer. Debounces three buttons, runs a timed
//            boot blink sequence, then steps through N_MODES run modes forward
//            or backward, with a halt/reboot toggle and a change strobe.
// Ports    : clk - system clock
//            rst - synchronous active-high reset
//            bus - mode_seq_if.slave (buttons in; state, mode, boot_phase,
//                  mode_strobe out)
// Options  : MODE_SEQ_LONGPRESS_EN - when defined, holding the debounced
//            next button for LONG_CYCLES in RUN returns to IDLE with mode 0.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef CLOCK_FREQ
`define CLOCK_FREQ 50_000_000
`endif

module mode_seq #(
  parameter int unsigned N_MODES         = 6,
  parameter int unsigned MODE_W          = 3,
  parameter int unsigned BOOT_PHASES     = 4,
  parameter int unsigned PHASE_W         = 2,
  parameter int unsigned BOOT_PERIOD     = `CLOCK_FREQ / 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = `CLOCK_FREQ
) (
  input  logic      clk,
  input  logic      rst,
  mode_seq_if.slave bus
);

  localparam int unsigned c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned c_PCNT_W = $clog2(BOOT_PERIOD + 1);

  localparam logic [c_DB_W-1:0]   c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PCNT_W-1:0] c_PCNT_LAST  = c_PCNT_W'(BOOT_PERIOD - 1);
  localparam logic [PHASE_W-1:0]  c_PHASE_LAST = PHASE_W'(BOOT_PHASES - 1);
  localparam logic [MODE_W-1:0]   c_MODE_LAST  = MODE_W'(N_MODES - 1);

  // Button bit positions in the front-end vectors.
  localparam int unsigned c_HALT = 0;
  localparam int unsigned c_NEXT = 1;
  localparam int unsigned c_PREV = 2;

  // Elaboration-time parameter sanity checks.
  if (N_MODES < 2 || (1 << MODE_W) < N_MODES) begin : g_bad_modes
    $error("mode_seq: N_MODES must be >= 2 and fit in MODE_W bits");
  end
  if (BOOT_PHASES < 1 || (1 << PHASE_W) < BOOT_PHASES) begin : g_bad_phases
    $error("mode_seq: BOOT_PHASES must be >= 1 and fit in PHASE_W bits");
  end
  if (BOOT_PERIOD < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_cycles
    $error("mode_seq: BOOT_PERIOD, DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Button front end: 2-flop synchroniser, debounce, registered rise detect
  // --------------------------------------------------------------------------
  logic [2:0]        w_raw;
  logic [2:0]        sync1_q, sync1_d;
  logic [2:0]        sync2_q, sync2_d;
  logic [2:0]        deb_q, deb_d;
  logic [2:0]        deb_prev_q, deb_prev_d;
  logic [2:0]        ev_q, ev_d;
  logic [c_DB_W-1:0] db_cnt_q [3];
  logic [c_DB_W-1:0] db_cnt_d [3];

  assign w_raw = {bus.btn_prev, bus.btn_next, bus.btn_halt};

  always_comb begin
    sync1_d    = w_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    ev_d       = deb_q & ~deb_prev_q;
    deb_d      = deb_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // The mismatch seen at the terminal count is the last one needed.
        if (db_cnt_q[i] == c_DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + c_DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      ev_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      ev_q       <= ev_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Simultaneous next and prev cancel each other.
  logic w_ev_halt, w_step_next, w_step_prev;
  assign w_ev_halt   = ev_q[c_HALT];
  assign w_step_next = ev_q[c_NEXT] & ~ev_q[c_PREV];
  assign w_step_prev = ev_q[c_PREV] & ~ev_q[c_NEXT];

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [PHASE_W-1:0]  boot_phase_q, boot_phase_d;
  logic [c_PCNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic                mode_strobe_q, mode_strobe_d;
  logic                w_long_fire;

`ifdef MODE_SEQ_LONGPRESS_EN
  // Hold timer for the debounced next button. It saturates at its terminal
  // count; fired_q keeps a single press from triggering more than once.
  localparam int unsigned          c_HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);

  logic [c_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                fired_q, fired_d;

  always_comb begin
    w_long_fire = (state_q == ST_RUN) && deb_q[c_NEXT] &&
                  (hold_cnt_q == c_HOLD_LAST) && !fired_q;
    hold_cnt_d  = '0;
    if ((state_q == ST_RUN) && deb_q[c_NEXT]) begin
      hold_cnt_d = (hold_cnt_q == c_HOLD_LAST) ? hold_cnt_q
                                               : hold_cnt_q + c_HOLD_W'(1);
    end
    fired_d = fired_q;
    if (!deb_q[c_NEXT]) begin
      fired_d = 1'b0;
    end else if (w_long_fire) begin
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      fired_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      fired_q    <= fired_d;
    end
  end
`else
  assign w_long_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    boot_phase_d = boot_phase_q;
    phase_cnt_d  = phase_cnt_q;

    if (w_ev_halt) begin
      // Halt toggle beats any step request in the same cycle.
      phase_cnt_d  = '0;
      boot_phase_d = '0;
      if (state_q == ST_HALT) begin
        state_d = ST_BOOT;
        mode_d  = '0;
      end else begin
        state_d = ST_HALT;
      end
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          if (phase_cnt_q == c_PCNT_LAST) begin
            phase_cnt_d = '0;
            if (boot_phase_q == c_PHASE_LAST) begin
              state_d      = ST_IDLE;
              boot_phase_d = '0;
            end else begin
              boot_phase_d = boot_phase_q + PHASE_W'(1);
            end
          end else begin
            phase_cnt_d = phase_cnt_q + c_PCNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_step_next) begin
            state_d = ST_RUN;
            mode_d  = '0;
          end else if (w_step_prev) begin
            state_d = ST_RUN;
            mode_d  = c_MODE_LAST;
          end
        end
        ST_RUN: begin
          // Explicit compare-and-wrap so non-power-of-two mode counts work.
          if (w_long_fire) begin
            state_d = ST_IDLE;
            mode_d  = '0;
          end else if (w_step_next) begin
            mode_d = (mode_q == c_MODE_LAST) ? '0 : mode_q + MODE_W'(1);
          end else if (w_step_prev) begin
            mode_d = (mode_q == '0) ? c_MODE_LAST : mode_q - MODE_W'(1);
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d      = ST_BOOT;
          mode_d       = '0;
          boot_phase_d = '0;
          phase_cnt_d  = '0;
        end
      endcase
    end

    // Registered so the pulse coincides with the new state/mode.
    mode_strobe_d = (state_d != state_q) || (mode_d != mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      mode_q        <= '0;
      boot_phase_q  <= '0;
      phase_cnt_q   <= '0;
      mode_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      boot_phase_q  <= boot_phase_d;
      phase_cnt_q   <= phase_cnt_d;
      mode_strobe_q <= mode_strobe_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.mode        = mode_q;
  assign bus.boot_phase  = boot_phase_q;
  assign bus.mode_strobe = mode_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_seq
// Purpose  : Self-checking bench for mode_seq: directed table, hand-written
//            corner sequences and randomized buttons against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mode_seq;
  localparam int N    = 3;
  localparam int PH   = 4;
  localparam int PER  = 4;
  localparam int DB   = 2;
  localparam int LONG = 10;
  localparam int MW   = 2;
  localparam int PW   = 2;

  localparam int S_BOOT = 0;
  localparam int S_IDLE = 1;
  localparam int S_RUN  = 2;
  localparam int S_HALT = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mode_seq_if #(.MODE_W(MW), .PHASE_W(PW)) bus ();

  mode_seq #(
    .N_MODES(N), .MODE_W(MW), .BOOT_PHASES(PH), .PHASE_W(PW),
    .BOOT_PERIOD(PER), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: debounced level flips once the last DB synchronised
  // samples all disagree with it; events reach the sequencer two edges later;
  // boot is a plain cycle timer; mode stepping uses modulo arithmetic.
  bit mh  [3][8];
  bit deb [3];
  bit r1  [3];
  bit r2  [3];
  int m_state, m_mode, m_timer, qual, m_strobe;
  bit fired;

  task automatic model_step();
    bit raw [3];
    bit ev  [3];
    bit cond, fire, all_diff, rose;
    int ps, pm;
    raw[0] = bus.btn_halt;
    raw[1] = bus.btn_next;
    raw[2] = bus.btn_prev;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        deb[b] = 0; r1[b] = 0; r2[b] = 0;
        for (int k = 0; k < 8; k++) mh[b][k] = 0;
      end
      m_state = S_BOOT; m_mode = 0; m_timer = 0; qual = 0; fired = 0; m_strobe = 0;
      return;
    end
    ps = m_state;
    pm = m_mode;
    for (int b = 0; b < 3; b++) ev[b] = r2[b];

    cond = (m_state == S_RUN) && deb[1];
    qual = cond ? qual + 1 : 0;
    fire = 0;
`ifdef MODE_SEQ_LONGPRESS_EN
    fire = cond && (qual == LONG) && !fired;
`endif
    if (!deb[1]) fired = 0;
    else if (fire) fired = 1;

    if (ev[0]) begin
      if (m_state == S_HALT) begin
        m_state = S_BOOT;
        m_mode  = 0;
      end else begin
        m_state = S_HALT;
      end
      m_timer = 0;
    end else begin
      case (m_state)
        S_BOOT: begin
          m_timer++;
          if (m_timer == PH * PER) begin
            m_state = S_IDLE;
            m_timer = 0;
          end
        end
        S_IDLE: begin
          if (ev[1] && !ev[2]) begin m_state = S_RUN; m_mode = 0; end
          else if (ev[2] && !ev[1]) begin m_state = S_RUN; m_mode = N - 1; end
        end
        S_RUN: begin
          if (fire) begin m_state = S_IDLE; m_mode = 0; end
          else if (ev[1] && !ev[2]) m_mode = (m_mode + 1) % N;
          else if (ev[2] && !ev[1]) m_mode = (m_mode + N - 1) % N;
        end
        default: ;
      endcase
    end

    for (int b = 0; b < 3; b++) begin
      all_diff = 1;
      for (int k = 1; k <= DB; k++) if (mh[b][k] == deb[b]) all_diff = 0;
      rose = 0;
      if (all_diff) begin
        rose   = !deb[b];
        deb[b] = !deb[b];
      end
      r2[b] = r1[b];
      r1[b] = rose;
      for (int k = 7; k > 0; k--) mh[b][k] = mh[b][k-1];
      mh[b][0] = raw[b];
    end
    m_strobe = (m_state != ps) || (m_mode != pm);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_state", bus.state, m_state);
    chk("model_mode", bus.mode, m_mode);
    chk("model_phase", bus.boot_phase, (m_state == S_BOOT) ? m_timer / PER : 0);
    chk("model_strobe", bus.mode_strobe, m_strobe);
  endtask

  task automatic set_btn(input bit h, input bit n, input bit p);
    bus.btn_halt = h;
    bus.btn_next = n;
    bus.btn_prev = p;
  endtask

  task automatic press(input bit h, input bit n, input bit p, input int hi, input int lo);
    set_btn(h, n, p);
    repeat (hi) tick();
    set_btn(0, 0, 0);
    repeat (lo) tick();
  endtask

  typedef struct {
    bit h; bit n; bit p;
    int exp_state; int exp_mode; int exp_strobes;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n_strobe, t_entry, t_idle;

    tbl[0] = '{0, 1, 0, S_RUN,  1, 1};
    tbl[1] = '{0, 1, 0, S_RUN,  2, 1};
    tbl[2] = '{0, 1, 0, S_RUN,  0, 1};
    tbl[3] = '{0, 0, 1, S_RUN,  2, 1};
    tbl[4] = '{0, 0, 1, S_RUN,  1, 1};
    tbl[5] = '{0, 1, 1, S_RUN,  1, 0};
    tbl[6] = '{1, 1, 0, S_HALT, 1, 1};
    tbl[7] = '{0, 1, 0, S_HALT, 1, 0};
    tbl[8] = '{0, 0, 1, S_HALT, 1, 0};

    rst = 1'b1;
    set_btn(0, 0, 0);
    repeat (3) tick();
    chk("reset_state", bus.state, S_BOOT);
    chk("reset_mode", bus.mode, 0);
    chk("reset_phase", bus.boot_phase, 0);
    chk("reset_strobe", bus.mode_strobe, 0);
    rst = 1'b0;

    // Boot: phase steps every PER cycles, IDLE after PH*PER cycles.
    n_strobe = 0;
    for (int k = 1; k <= PH * PER; k++) begin
      tick();
      n_strobe += int'(bus.mode_strobe);
      if (k < PH * PER) begin
        chk("boot_phase", bus.boot_phase, k / PER);
        chk("boot_state", bus.state, S_BOOT);
      end
    end
    chk("boot_done_state", bus.state, S_IDLE);
    chk("boot_strobes", n_strobe, 1);

    // Button latency: raw rise at edge 0 lands after edge DB+3.
    set_btn(0, 1, 0);
    for (int j = 0; j <= DB + 3; j++) begin
      tick();
      if (j == DB + 2) begin
        chk("lat_before", bus.state, S_IDLE);
        set_btn(0, 0, 0);
      end
    end
    chk("lat_state", bus.state, S_RUN);
    chk("lat_mode", bus.mode, 0);
    chk("lat_strobe", bus.mode_strobe, 1);
    repeat (7) tick();

    for (int i = 0; i < 9; i++) begin
      n_strobe = 0;
      set_btn(tbl[i].h, tbl[i].n, tbl[i].p);
      repeat (5) begin tick(); n_strobe += int'(bus.mode_strobe); end
      set_btn(0, 0, 0);
      repeat (7) begin tick(); n_strobe += int'(bus.mode_strobe); end
      chk($sformatf("vec%0d_state", i), bus.state, tbl[i].exp_state);
      chk($sformatf("vec%0d_mode", i), bus.mode, tbl[i].exp_mode);
      chk($sformatf("vec%0d_strobes", i), n_strobe, tbl[i].exp_strobes);
    end

    // Reboot from HALT: BOOT after DB+3 edges, then a full boot.
    t_entry = -1;
    t_idle  = -1;
    set_btn(1, 0, 0);
    for (int t = 0; t < 60; t++) begin
      tick();
      if (t == 4) set_btn(0, 0, 0);
      if (t_entry < 0 && bus.state == S_BOOT) begin
        t_entry = t;
        chk("reboot_mode", bus.mode, 0);
      end
      if (t_entry >= 0 && bus.state == S_IDLE) begin
        t_idle = t;
        break;
      end
    end
    set_btn(0, 0, 0);
    chk("reboot_latency", t_entry, DB + 3);
    chk("reboot_len", t_idle - t_entry, PH * PER);

    // Reverse entry and wrap.
    press(0, 0, 1, 5, 7);
    chk("rev1_state", bus.state, S_RUN);
    chk("rev1_mode", bus.mode, N - 1);
    press(0, 0, 1, 5, 7);
    chk("rev2_mode", bus.mode, N - 2);

    // One-cycle glitch is filtered.
    n_strobe = 0;
    set_btn(0, 1, 0);
    tick();
    n_strobe += int'(bus.mode_strobe);
    set_btn(0, 0, 0);
    repeat (10) begin tick(); n_strobe += int'(bus.mode_strobe); end
    chk("glitch_mode", bus.mode, 1);
    chk("glitch_strobes", n_strobe, 0);

    // Long hold of next from RUN mode 0.
    press(0, 0, 1, 5, 7);
    chk("lp_start_mode", bus.mode, 0);
    n_strobe = 0;
    set_btn(0, 1, 0);
    for (int j = 0; j < 20; j++) begin
      tick();
      n_strobe += int'(bus.mode_strobe);
      if (j == 5) begin
        chk("lp_step_state", bus.state, S_RUN);
        chk("lp_step_mode", bus.mode, 1);
      end
      if (j == 12) chk("lp_pre_state", bus.state, S_RUN);
`ifdef MODE_SEQ_LONGPRESS_EN
      if (j == 13) begin
        chk("lp_fire_state", bus.state, S_IDLE);
        chk("lp_fire_mode", bus.mode, 0);
      end
`endif
    end
    set_btn(0, 0, 0);
    repeat (8) begin tick(); n_strobe += int'(bus.mode_strobe); end
`ifdef MODE_SEQ_LONGPRESS_EN
    chk("lp_final_state", bus.state, S_IDLE);
    chk("lp_final_mode", bus.mode, 0);
    chk("lp_strobes", n_strobe, 2);
`else
    chk("lp_final_state", bus.state, S_RUN);
    chk("lp_final_mode", bus.mode, 1);
    chk("lp_strobes", n_strobe, 1);
`endif

    // Reset during boot phase 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    chk("pre_rst_phase", bus.boot_phase, 2);
    rst = 1'b1;
    tick();
    chk("rst_phase", bus.boot_phase, 0);
    chk("rst_state", bus.state, S_BOOT);
    rst = 1'b0;

    // Randomized buttons and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(11) == 0) bus.btn_halt = ~bus.btn_halt;
      if ($urandom_range(3) == 0)  bus.btn_next = ~bus.btn_next;
      if ($urandom_range(3) == 0)  bus.btn_prev = ~bus.btn_prev;
      rst = ($urandom_range(399) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
